// File: rtl/bt_cmd_pkg.sv
// Shared constants and types for the Bluetooth motor command decoder.
// ASCII command codes, receiver FSM states and the byte-to-command decode.
package bt_cmd_pkg;

  localparam logic [7:0] CMD_FWD_U  = 8'h46;
  localparam logic [7:0] CMD_FWD_L  = 8'h66;
  localparam logic [7:0] CMD_REV_U  = 8'h52;
  localparam logic [7:0] CMD_REV_L  = 8'h72;
  localparam logic [7:0] CMD_STOP_U = 8'h53;
  localparam logic [7:0] CMD_STOP_L = 8'h73;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  typedef enum logic [1:0] {CMD_UNK, CMD_FWD, CMD_REV, CMD_STOP} cmd_t;

  function automatic cmd_t decode_cmd(input logic [7:0] b);
    case (b)
      CMD_FWD_U, CMD_FWD_L:   return CMD_FWD;
      CMD_REV_U, CMD_REV_L:   return CMD_REV;
      CMD_STOP_U, CMD_STOP_L: return CMD_STOP;
      default:                return CMD_UNK;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling FSM, byte/valid/framing-error outputs.
// Returns to IDLE right after the stop-bit sample so a back-to-back start edge is not missed.
module uart_rx_core
  import bt_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic            r_sync1, r_sync2, r_rx_d;
  rx_state_t       r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [2:0]      r_bit_idx, w_bit_n;
  logic [7:0]      r_shift, w_shift_n;
  logic [7:0]      r_byte, w_byte_n;
  logic            r_valid, w_valid_n;
  logic            r_ferr, w_ferr_n;
  logic            w_fall, w_tick;

  assign w_fall = r_rx_d & ~r_sync2;
  // Start bit is checked at half a bit; every later sample is one full bit apart.
  assign w_tick = (r_state == START) ? (r_cnt == HALF_M1) : (r_cnt == FULL_M1);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 1'b1;
    w_bit_n   = r_bit_idx;
    w_shift_n = r_shift;
    w_byte_n  = r_byte;
    w_valid_n = 1'b0;
    w_ferr_n  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_n = '0;
        if (w_fall) w_state_n = START;
      end
      START: begin
        if (w_tick) begin
          w_cnt_n = '0;
          if (r_sync2) begin
            w_state_n = IDLE;
          end else begin
            w_state_n = DATA;
            w_bit_n   = '0;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          w_cnt_n   = '0;
          w_shift_n = {r_sync2, r_shift[7:1]};
          w_bit_n   = r_bit_idx + 1'b1;
          if (r_bit_idx == 3'd7) w_state_n = STOP;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_cnt_n   = '0;
          w_state_n = IDLE;
          if (r_sync2) begin
            w_valid_n = 1'b1;
            w_byte_n  = r_shift;
          end else begin
            w_ferr_n  = 1'b1;
          end
        end
      end
      default: begin
        w_state_n = IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_d    <= 1'b1;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_byte    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_sync1   <= uart_rx;
      r_sync2   <= r_sync1;
      r_rx_d    <= r_sync2;
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_bit_idx <= w_bit_n;
      r_shift   <= w_shift_n;
      r_byte    <= w_byte_n;
      r_valid   <= w_valid_n;
      r_ferr    <= w_ferr_n;
    end
  end

  assign rx_byte   = r_byte;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;

endmodule

// File: rtl/bt_motor_cmd_decoder.sv
// Turns Bluetooth UART bytes into forward/reverse/stop pulses for the motor controller,
// with a safety stop on framing errors and on link silence while the motor runs.
module bt_motor_cmd_decoder
  import bt_cmd_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 9600,
  parameter int WDOG_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       forward_cmd,
  output logic       reverse_cmd,
  output logic       stop_cmd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       unknown_cmd,
  output logic       running
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int WW = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WD_TERM = WW'(WDOG_CYCLES);
  localparam logic [WW-1:0] WD_LAST = (WDOG_CYCLES > 0) ? WW'(WDOG_CYCLES - 1) : '0;

  logic [7:0]    w_byte;
  logic          w_valid, w_ferr, w_wd_hit;
  cmd_t          w_cmd;
  logic          r_fwd, r_rev, r_stop, r_unk, r_running;
  logic [WW-1:0] r_wd_cnt;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .rx_byte  (w_byte),
    .rx_valid (w_valid),
    .frame_err(w_ferr)
  );

  assign w_cmd = decode_cmd(w_byte);
  // A byte arriving on the terminal count suppresses the watchdog; its decode takes over.
  assign w_wd_hit = (WDOG_CYCLES > 0) && r_running && !w_valid && (r_wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd     <= 1'b0;
      r_rev     <= 1'b0;
      r_stop    <= 1'b0;
      r_unk     <= 1'b0;
      r_running <= 1'b0;
      r_wd_cnt  <= '0;
    end else begin
      r_fwd  <= w_valid && (w_cmd == CMD_FWD);
      r_rev  <= w_valid && (w_cmd == CMD_REV);
      r_stop <= (w_valid && (w_cmd == CMD_STOP)) || w_wd_hit;
      r_unk  <= w_valid && (w_cmd == CMD_UNK);
      if (stop_cmd)            r_running <= 1'b0;
      else if (r_fwd || r_rev) r_running <= 1'b1;
      if (w_valid || !r_running) r_wd_cnt <= '0;
      else if (r_wd_cnt != WD_TERM) r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign forward_cmd = r_fwd;
  assign reverse_cmd = r_rev;
  // Framing-error stop is not delayed so it coincides with frame_err.
  assign stop_cmd    = r_stop | w_ferr;
  assign unknown_cmd = r_unk;
  assign running     = r_running;
  assign rx_byte     = w_byte;
  assign rx_valid    = w_valid;
  assign frame_err   = w_ferr;

endmodule

// File: tb/tb_bt_motor_cmd_decoder.sv
// Bench for bt_motor_cmd_decoder: directed table, corner sequences and random bytes vs a model.
module tb_bt_motor_cmd_decoder;

  localparam int CPB = 16;
  localparam int WD  = 2000;
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1;
  logic       forward_cmd, reverse_cmd, stop_cmd, rx_valid, frame_err, unknown_cmd, running;
  logic [7:0] rx_byte;

  bt_motor_cmd_decoder #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .WDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .forward_cmd(forward_cmd), .reverse_cmd(reverse_cmd), .stop_cmd(stop_cmd),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err),
    .unknown_cmd(unknown_cmd), .running(running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0, n_fwd = 0, n_rev = 0, n_stop = 0, n_unk = 0, n_ferr = 0;
  int valid_cyc = 0, cmd_cyc = 0, stop_cyc = 0, ferr_cyc = 0, rise_cyc = 0, excl_err = 0;
  logic run_q = 1'b0;

  always @(negedge clk) begin
    if (rx_valid)    begin n_valid <= n_valid + 1; valid_cyc <= cyc; end
    if (forward_cmd) begin n_fwd <= n_fwd + 1; cmd_cyc <= cyc; end
    if (reverse_cmd) begin n_rev <= n_rev + 1; cmd_cyc <= cyc; end
    if (stop_cmd)    begin n_stop <= n_stop + 1; cmd_cyc <= cyc; stop_cyc <= cyc; end
    if (unknown_cmd) begin n_unk <= n_unk + 1; cmd_cyc <= cyc; end
    if (frame_err)   begin n_ferr <= n_ferr + 1; ferr_cyc <= cyc; end
    if (running && !run_q) rise_cyc <= cyc;
    run_q <= running;
    if (int'(forward_cmd) + int'(reverse_cmd) + int'(stop_cmd) > 1) excl_err <= excl_err + 1;
  end

  typedef struct {
    logic [7:0] b0, b1;
    int         nb;
    bit         ok;
    int         e_valid, e_fwd, e_rev, e_stop, e_unk, e_ferr;
    logic [7:0] e_byte;
    bit         e_run;
  } vec_t;

  int vectors = 0, miscompares = 0;
  logic [7:0] m_byte;
  bit         m_run;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok, output int start);
    @(posedge clk); #1 uart_rx = 1'b0; start = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 uart_rx = b[i];
    end
    repeat (CPB) @(posedge clk);
    #1 uart_rx = ok;
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int bv, bf, br, bs, bu, be, st;
    bv = n_valid; bf = n_fwd; br = n_rev; bs = n_stop; bu = n_unk; be = n_ferr;
    send_byte(v.b0, (v.nb == 2) ? 1'b1 : v.ok, st);
    if (v.nb == 2) send_byte(v.b1, v.ok, st);
    @(posedge clk); #1 uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk({tag, ".rx_valid"}, n_valid - bv, v.e_valid);
    chk({tag, ".forward"},  n_fwd - bf,   v.e_fwd);
    chk({tag, ".reverse"},  n_rev - br,   v.e_rev);
    chk({tag, ".stop"},     n_stop - bs,  v.e_stop);
    chk({tag, ".unknown"},  n_unk - bu,   v.e_unk);
    chk({tag, ".frame_err"}, n_ferr - be, v.e_ferr);
    chk({tag, ".rx_byte"},  int'(rx_byte), int'(v.e_byte));
    chk({tag, ".running"},  int'(running), int'(v.e_run));
    if (v.ok) begin
      chk({tag, ".valid_latency"}, valid_cyc - st, LAT);
      chk({tag, ".cmd_latency"}, cmd_cyc - valid_cyc, 1);
    end else begin
      chk({tag, ".ferr_stop_same_cycle"}, stop_cyc - ferr_cyc, 0);
    end
  endtask

  // Reference: uppercase the byte, map to the command it names, track last byte and running.
  function automatic vec_t model(input logic [7:0] b, input bit ok);
    vec_t v;
    logic [7:0] up;
    v = '{b, 8'h00, 1, ok, 0, 0, 0, 0, 0, 0, m_byte, m_run};
    up = (b >= 8'h61 && b <= 8'h7a) ? b - 8'h20 : b;
    if (!ok) begin
      v.e_ferr = 1; v.e_stop = 1; v.e_run = 1'b0;
    end else begin
      v.e_valid = 1; v.e_byte = b;
      if (up == 8'h46)      begin v.e_fwd = 1;  v.e_run = 1'b1; end
      else if (up == 8'h52) begin v.e_rev = 1;  v.e_run = 1'b1; end
      else if (up == 8'h53) begin v.e_stop = 1; v.e_run = 1'b0; end
      else                  v.e_unk = 1;
    end
    return v;
  endfunction

  task automatic model_vec(input logic [7:0] b, input bit ok, input string tag);
    vec_t v;
    v = model(b, ok);
    run_vec(v, tag);
    m_byte = v.e_byte; m_run = v.e_run;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: run did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[8];
    logic [7:0] cmds[6];
    int base, bs, bf, st;
    tbl[0] = '{8'h46, 8'h00, 1, 1'b1, 1, 1, 0, 0, 0, 0, 8'h46, 1'b1};
    tbl[1] = '{8'h72, 8'h73, 2, 1'b1, 2, 0, 1, 1, 0, 0, 8'h73, 1'b0};
    tbl[2] = '{8'h66, 8'h00, 1, 1'b1, 1, 1, 0, 0, 0, 0, 8'h66, 1'b1};
    tbl[3] = '{8'h58, 8'h00, 1, 1'b1, 1, 0, 0, 0, 1, 0, 8'h58, 1'b1};
    tbl[4] = '{8'h72, 8'h00, 1, 1'b1, 1, 0, 1, 0, 0, 0, 8'h72, 1'b1};
    tbl[5] = '{8'h46, 8'h00, 1, 1'b0, 0, 0, 0, 1, 0, 1, 8'h72, 1'b0};
    tbl[6] = '{8'h58, 8'h00, 1, 1'b1, 1, 0, 0, 0, 1, 0, 8'h58, 1'b0};
    tbl[7] = '{8'h53, 8'h00, 1, 1'b1, 1, 0, 0, 1, 0, 0, 8'h53, 1'b0};
    cmds = '{8'h46, 8'h66, 8'h52, 8'h72, 8'h53, 8'h73};

    // Reset state
    #23;
    chk("reset.rx_byte", int'(rx_byte), 0);
    chk("reset.pulses", int'({forward_cmd, reverse_cmd, stop_cmd, rx_valid, frame_err, unknown_cmd}), 0);
    chk("reset.running", int'(running), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));
    m_byte = tbl[7].e_byte; m_run = tbl[7].e_run;

    // Short low glitches are false starts and produce nothing
    for (int g = 0; g < 2; g++) begin
      base = n_valid + n_fwd + n_rev + n_stop + n_unk + n_ferr;
      @(posedge clk); #1 uart_rx = 1'b0;
      repeat ((g == 0) ? CPB / 2 - 2 : 1) @(posedge clk);
      #1 uart_rx = 1'b1;
      repeat (12 * CPB) @(posedge clk);
      #1 chk($sformatf("glitch%0d.no_output", g), n_valid + n_fwd + n_rev + n_stop + n_unk + n_ferr - base, 0);
    end

    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      int r;
      r = $urandom_range(0, 9);
      b = (r < 6) ? cmds[r] : 8'($urandom);
      model_vec(b, $urandom_range(0, 7) != 0, $sformatf("rnd%0d", i));
    end

    // Watchdog expiry
    model_vec(8'h53, 1'b1, "wd.pre_stop");
    model_vec(8'h46, 1'b1, "wd.fwd");
    bs = n_stop; bf = n_fwd;
    for (int i = 0; i < 3 * WD && n_stop == bs; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("wd.fired", n_stop - bs, 1);
    chk("wd.delay", stop_cyc - rise_cyc, WD);
    chk("wd.running_cleared", int'(running), 0);
    chk("wd.no_other_cmd", n_fwd - bf, 0);
    m_run = 1'b0;

    // Watchdog kept alive by regular bytes
    model_vec(8'h52, 1'b1, "wd.rev");
    bs = n_stop;
    for (int i = 0; i < 6; i++) begin
      repeat (800) @(posedge clk);
      model_vec(8'h58, 1'b1, $sformatf("wd.keepalive%0d", i));
    end
    chk("wd.kept_alive_no_stop", n_stop - bs, 0);
    chk("wd.kept_alive_running", int'(running), 1);
    model_vec(8'h73, 1'b1, "wd.stop");

    // Reset in the middle of data bit 4
    model_vec(8'h46, 1'b1, "rst.pre_fwd");
    @(posedge clk); #1 uart_rx = 1'b0; st = cyc;
    for (int i = 0; i < 5; i++) begin
      repeat (CPB) @(posedge clk);
      #1 uart_rx = cmds[4][i];
    end
    repeat (CPB / 2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.rx_byte", int'(rx_byte), 0);
    chk("rst.running", int'(running), 0);
    chk("rst.pulses", int'({forward_cmd, reverse_cmd, stop_cmd, rx_valid, frame_err, unknown_cmd}), 0);
    uart_rx = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    base = n_valid + n_ferr + n_stop;
    repeat (12 * CPB) @(posedge clk);
    #1 chk("rst.partial_lost", n_valid + n_ferr + n_stop - base, 0);
    m_byte = 8'h00; m_run = 1'b0;
    model_vec(8'h53, 1'b1, "rst.post_S");

    chk("one_hot_cmds", excl_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bt_motor_cmd_decoder.md
# bt_motor_cmd_decoder

Receives the Bluetooth module's UART byte stream (8N1) and converts ASCII motor commands into the single-cycle forward_cmd / reverse_cmd / stop_cmd pulses consumed by the DC motor controller's manual-control port. It sits between the Bluetooth pin and the motor controller. It adds a safety stop on framing errors and on link silence while the motor is running.

## Interface
Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz
- BAUD, 9600, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 5208 at defaults)
- WDOG_CYCLES, 50_000_000, silence timeout in clk cycles while running; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- uart_rx  in  1  asynchronous serial input, idle high
- forward_cmd  out  1  one-cycle pulse, 'F'/'f' received
- reverse_cmd  out  1  one-cycle pulse, 'R'/'r' received
- stop_cmd  out  1  one-cycle pulse: 'S'/'s', framing error, or watchdog
- rx_byte  out  8  last correctly framed byte, held until the next one
- rx_valid  out  1  one-cycle pulse, rx_byte updated
- frame_err  out  1  one-cycle pulse, stop bit sampled low
- unknown_cmd  out  1  one-cycle pulse, framed byte is not a command
- running  out  1  high after forward/reverse, low after any stop_cmd

## Operation
- uart_rx passes through a 2-FF synchronizer whose flops reset to 1. Edge detection uses the synchronized signal only.
- RX FSM states:
  - IDLE: a falling edge starts the bit counter and moves to START.
  - START: at CLKS_PER_BIT/2, if rx is still low go to DATA; if rx is high, treat it as a false start and return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT at mid-bit, LSB first, 8 bits, then go to STOP.
  - STOP: sample at mid-bit. A 1 gives a valid byte; a 0 gives a framing error. Return to IDLE immediately after this sample, so a back-to-back start bit is caught.
- Decode of a valid byte:
  - 0x46/0x66 gives forward_cmd.
  - 0x52/0x72 gives reverse_cmd.
  - 0x53/0x73 gives stop_cmd.
  - Any other byte gives unknown_cmd and no motor pulse.
- A framing error discards the byte, leaves rx_byte unchanged, and pulses frame_err and stop_cmd in the same cycle.
- At most one of forward_cmd, reverse_cmd, stop_cmd is high in any cycle.
- running:
  - Set by forward_cmd or reverse_cmd.
  - Cleared by stop_cmd from any source.
- Watchdog (WDOG_CYCLES > 0):
  - The counter clears on every rx_valid and whenever running = 0.
  - It counts while running = 1.
  - On reaching WDOG_CYCLES it pulses stop_cmd once and clears running.
  - If rx_valid arrives in the same cycle as the terminal count, the byte's decode wins and the counter clears.
- Reset, including mid-byte:
  - All outputs go to 0, rx_byte goes to 0x00, FSM to IDLE, counters to 0.
  - A partial byte is lost, with no frame_err.
  - After rst_n deasserts, the receiver waits for a fresh falling edge.

## Timing
- Synchronizer latency: 2 cycles.
- The stop-bit mid-sample occurs 9.5 bit times after the start edge is detected. rx_valid, frame_err and rx_byte update on the next clk edge.
- Command decode is registered: forward_cmd / reverse_cmd / stop_cmd / unknown_cmd assert exactly 1 cycle after rx_valid. The framing-error stop_cmd is the exception: it asserts in the same cycle as frame_err.
- running changes on the clk edge after the command pulse.
- Bit counter width: $clog2(CLKS_PER_BIT). The count reloads on every sample and never wraps freely.
- Watchdog counter width: $clog2(WDOG_CYCLES+1). It saturates at the terminal count, with no wrap.

## Structure
- Package bt_cmd_pkg holds:
  - ASCII constants CMD_FWD_U/L, CMD_REV_U/L, CMD_STOP_U/L
  - the rx_state_t enum (IDLE, START, DATA, STOP)
- Sub-module uart_rx_core contains the synchronizer, RX FSM, rx_byte, rx_valid and frame_err.
- The top level holds the decode, running flag and watchdog.

## Test plan
- Send 0x46 at 9600 baud → one rx_valid with rx_byte = 0x46. forward_cmd pulses 1 cycle later; running = 1.
- Send 0x72 then 0x73 back-to-back (no idle gap) → reverse_cmd, then stop_cmd. Both bytes are received and running ends at 0.
- Send 0x58 → unknown_cmd pulse only. No forward/reverse/stop pulse; running is unchanged.
- Send 0x46 with the stop bit forced low → frame_err and stop_cmd pulse in the same cycle; rx_byte keeps its prior value. Separately, hold uart_rx low for 1000 cycles → no output at all.
- Set WDOG_CYCLES = 100_000 and send 'F' → stop_cmd exactly 100_000 cycles after running rises. With a valid byte every 50_000 cycles instead → no watchdog stop.
- Assert rst_n low during data bit 4 of a byte → all outputs 0 immediately. The next complete 'S' is decoded correctly.
